lvt_table_4port: RTL

Live-value table for the 4-port multiported cache: one `LVT_ENTRY` per cache line recording which port last wrote that line. Sits directly upstream of the per-read-port word muxes. Each read port's registered selector is presented alongside the banked-RAM read data, so the downstream mux picks the live copy. Also provides a run-time flush sequencer that resets every entry to `ACCEL_0`.

---
 rtl/lvt_table_4port_pkg.sv | 19 +
 rtl/lvt_table_4port_if.sv | 32 +++
 rtl/lvt_write_arbiter.sv | 32 +++
 rtl/lvt_table_4port.sv | 133 +++++++++++++
 4 files changed

// File: rtl/lvt_table_4port_pkg.sv
// Shared types and constants for the 4-port live-value table.
package lvt_table_4port_pkg;

   typedef logic [1:0] lvt_entry_t;

   localparam lvt_entry_t ACCEL_0 = 2'd0;
   localparam lvt_entry_t ACCEL_1 = 2'd1;
   localparam lvt_entry_t ACCEL_2 = 2'd2;
   localparam lvt_entry_t ACCEL_3 = 2'd3;

   localparam int unsigned LVT_DEPTH = 256;
   localparam int unsigned LVT_NPORT = 4;

   typedef enum logic {
      FLUSH_IDLE  = 1'b0,
      FLUSH_SWEEP = 1'b1
   } flush_state_e;

endpackage

// File: rtl/lvt_table_4port_if.sv
// Port-side bundle of the live-value table: four write ports, four read ports, flush control.
interface lvt_table_4port_if #(
   parameter int unsigned ADDR_W = 8
);
   import lvt_table_4port_pkg::*;

   logic              wr_en_0, wr_en_1, wr_en_2, wr_en_3;
   logic [ADDR_W-1:0] wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3;
   logic [ADDR_W-1:0] rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
   lvt_entry_t        selector_0, selector_1, selector_2, selector_3;
   logic              flush;
   logic              busy;

   modport master (
      output wr_en_0, wr_en_1, wr_en_2, wr_en_3,
      output wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3,
      output rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
      output flush,
      input  selector_0, selector_1, selector_2, selector_3,
      input  busy
   );

   modport slave (
      input  wr_en_0, wr_en_1, wr_en_2, wr_en_3,
      input  wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3,
      input  rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
      input  flush,
      output selector_0, selector_1, selector_2, selector_3,
      output busy
   );

endinterface

// File: rtl/lvt_write_arbiter.sv
// Resolves the four port writes plus the sweep clear targeting one index into a write enable and value.
module lvt_write_arbiter
   import lvt_table_4port_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic [ADDR_W-1:0]                idx,
   input  logic [LVT_NPORT-1:0]             wr_en,
   input  logic [LVT_NPORT-1:0][ADDR_W-1:0] wr_addr,
   input  logic                             sweep_en,
   input  logic [ADDR_W-1:0]                sweep_addr,
   output logic                             wr_c,
   output lvt_entry_t                       next_val_c
);

   // Walk from port 3 down so lower-numbered ports overwrite; the sweep clear beats all ports.
   always_comb begin
      wr_c       = 1'b0;
      next_val_c = ACCEL_0;
      for (int k = LVT_NPORT - 1; k >= 0; k--) begin
         if (wr_en[k] && (wr_addr[k] == idx)) begin
            wr_c       = 1'b1;
            next_val_c = 2'(k);
         end
      end
      if (sweep_en && (sweep_addr == idx)) begin
         wr_c       = 1'b1;
         next_val_c = ACCEL_0;
      end
   end

endmodule

// File: rtl/lvt_table_4port.sv
// Live-value table for the 4-port cache: tracks the last writer per line and sweeps the table on flush.
// Optional macro LVT_BYPASS_EN forwards same-cycle writes to the read selectors.
module lvt_table_4port
   import lvt_table_4port_pkg::*;
#(
   parameter int unsigned DEPTH  = LVT_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   lvt_table_4port_if.slave bus
);

   logic [LVT_NPORT-1:0]             wr_en;
   logic [LVT_NPORT-1:0][ADDR_W-1:0] wr_addr;
   logic [LVT_NPORT-1:0][ADDR_W-1:0] rd_addr;
   lvt_entry_t [LVT_NPORT-1:0]       rd_val_c;
   lvt_entry_t [LVT_NPORT-1:0]       sel_q;

   lvt_entry_t                       entry [DEPTH];
   logic [DEPTH-1:0]                 ent_we;
   lvt_entry_t [DEPTH-1:0]           ent_nv;

   flush_state_e                     state;
   logic [ADDR_W-1:0]                cnt;
   logic                             busy_q;
   logic                             sweep_en;

   assign wr_en   = {bus.wr_en_3, bus.wr_en_2, bus.wr_en_1, bus.wr_en_0};
   assign wr_addr = {bus.wr_addr_3, bus.wr_addr_2, bus.wr_addr_1, bus.wr_addr_0};
   assign rd_addr = {bus.rd_addr_3, bus.rd_addr_2, bus.rd_addr_1, bus.rd_addr_0};
   assign sweep_en = (state == FLUSH_SWEEP);

   // Flush sequencer: one entry cleared per cycle, flush ignored while sweeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= FLUSH_IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            FLUSH_IDLE: begin
               if (bus.flush) begin
                  state  <= FLUSH_SWEEP;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            FLUSH_SWEEP: begin
               cnt <= cnt + ADDR_W'(1);
               if (cnt == ADDR_W'(DEPTH - 1)) begin
                  state  <= FLUSH_IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= FLUSH_IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      lvt_write_arbiter #(.ADDR_W(ADDR_W)) u_arb (
         .idx        (IDX),
         .wr_en      (wr_en),
         .wr_addr    (wr_addr),
         .sweep_en   (sweep_en),
         .sweep_addr (cnt),
         .wr_c       (ent_we[i]),
         .next_val_c (ent_nv[i])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) entry[i] <= ACCEL_0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_we[i]) entry[i] <= ent_nv[i];
         end
      end
   end

`ifdef LVT_BYPASS_EN
   logic [LVT_NPORT-1:0]       byp_we;
   lvt_entry_t [LVT_NPORT-1:0] byp_nv;

   // Same arbitration evaluated at each read address forwards the winning write.
   for (genvar k = 0; k < LVT_NPORT; k++) begin : g_byp
      lvt_write_arbiter #(.ADDR_W(ADDR_W)) u_byp (
         .idx        (rd_addr[k]),
         .wr_en      (wr_en),
         .wr_addr    (wr_addr),
         .sweep_en   (sweep_en),
         .sweep_addr (cnt),
         .wr_c       (byp_we[k]),
         .next_val_c (byp_nv[k])
      );
   end

   always_comb begin
      for (int k = 0; k < LVT_NPORT; k++) begin
         rd_val_c[k] = byp_we[k] ? byp_nv[k] : entry[rd_addr[k]];
      end
   end
`else
   always_comb begin
      for (int k = 0; k < LVT_NPORT; k++) begin
         rd_val_c[k] = entry[rd_addr[k]];
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q <= '0;
      end else begin
         sel_q <= rd_val_c;
      end
   end

   assign bus.selector_0 = sel_q[0];
   assign bus.selector_1 = sel_q[1];
   assign bus.selector_2 = sel_q[2];
   assign bus.selector_3 = sel_q[3];
   assign bus.busy       = busy_q;

endmodule
